// File: rtl/neuron_accumulator_pkg.sv
// Shared fixed-point and neuron-pipeline definitions.
// Operand format, activation-mask width and the accumulator FSM states.
package definitions;

   parameter int unsigned Q_INT         = 8;
   parameter int unsigned Q_FRAC        = 8;
   parameter int unsigned ACT_MASK_SIZE = 4;
   parameter int unsigned ACC_GUARD     = 8;

   typedef enum logic [1:0] {
      ACC_ACCUM = 2'd0,
      ACC_FLUSH = 2'd1,
      ACC_HOLD  = 2'd2
   } AccState;

endpackage

// File: rtl/neuron_accumulator_sat_truncate.sv
// Requantiser: wide signed value -> signed OUT_W by dropping SHIFT low bits (floor),
// clipping to the representable range and flagging any clip.
module sat_truncate #(
   parameter int unsigned IN_W  = 40,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned SHIFT = 8
) (
   input  logic signed [IN_W-1:0]  in_val,
   output logic signed [OUT_W-1:0] out_val,
   output logic                    ovf
);

   logic signed [IN_W-1:0]  shifted;
   logic [IN_W-OUT_W:0]     top_bits;

   assign shifted  = in_val >>> SHIFT;
   assign top_bits = shifted[IN_W-1:OUT_W-1];

   // Fits only when every bit from the output sign bit upwards agrees.
   always_comb begin
      ovf     = !((&top_bits) || !(|top_bits));
      out_val = shifted[OUT_W-1:0];
      if (ovf) begin
         out_val = shifted[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/neuron_accumulator.sv
// Streaming MAC producing one saturated Q_INT.Q_FRAC neuron pre-activation per vector,
// held with its activation mask until the downstream stage accepts it.
module neuron_accumulator #(
   parameter int unsigned Q_INT     = definitions::Q_INT,
   parameter int unsigned Q_FRAC    = definitions::Q_FRAC,
   parameter int unsigned MASK_W    = definitions::ACT_MASK_SIZE,
   parameter int unsigned ACC_GUARD = definitions::ACC_GUARD
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic signed [Q_INT+Q_FRAC-1:0]  s_w,
   input  logic signed [Q_INT+Q_FRAC-1:0]  s_x,
   input  logic                            s_last,
   input  logic [MASK_W-1:0]               s_mask,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic signed [Q_INT+Q_FRAC-1:0]  m_x,
   output logic [MASK_W-1:0]               m_mask,
   output logic                            m_sat
);
   import definitions::*;

   localparam int unsigned W  = Q_INT + Q_FRAC;
   localparam int unsigned PW = 2 * W;
   localparam int unsigned AW = PW + ACC_GUARD;

   localparam logic [ACC_GUARD:0] CNT_MAX = {1'b1, {ACC_GUARD{1'b0}}};
   localparam logic [ACC_GUARD:0] CNT_ONE = {{ACC_GUARD{1'b0}}, 1'b1};

   AccState               state;
   logic signed [PW-1:0]  p;
   logic                  p_vld;
   logic signed [AW-1:0]  acc;
   logic signed [AW-1:0]  p_ext;
   logic signed [AW-1:0]  sum;
   logic [ACC_GUARD:0]    cnt;
   logic                  over;
   logic                  hs;
   logic signed [W-1:0]   sat_x;
   logic                  sat_ovf;

   assign s_ready = (state == ACC_ACCUM);
   assign hs      = s_valid && s_ready;
   assign p_ext   = p_vld ? {{ACC_GUARD{p[PW-1]}}, p} : '0;
   assign sum     = acc + p_ext;

   sat_truncate #(
      .IN_W  (AW),
      .OUT_W (W),
      .SHIFT (Q_FRAC)
   ) u_sat (
      .in_val  (sum),
      .out_val (sat_x),
      .ovf     (sat_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ACC_ACCUM;
         p       <= '0;
         p_vld   <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         over    <= 1'b0;
         m_valid <= 1'b0;
         m_x     <= '0;
         m_mask  <= '0;
         m_sat   <= 1'b0;
      end else begin
         unique case (state)
            ACC_ACCUM: begin
               if (hs) begin
                  // Product is pipelined; the previous one is folded into acc on this edge.
                  p     <= PW'(s_w) * PW'(s_x);
                  p_vld <= 1'b1;
                  acc   <= sum;
                  if (cnt == '0) begin
                     m_mask <= s_mask;
                  end
                  if (cnt == CNT_MAX) begin
                     over <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
                  if (s_last) begin
                     state <= ACC_FLUSH;
                  end
               end else if (p_vld) begin
                  acc   <= sum;
                  p_vld <= 1'b0;
               end
            end
            ACC_FLUSH: begin
               m_x     <= sat_x;
               m_sat   <= sat_ovf || over;
               m_valid <= 1'b1;
               acc     <= '0;
               p_vld   <= 1'b0;
               cnt     <= '0;
               over    <= 1'b0;
               state   <= ACC_HOLD;
            end
            ACC_HOLD: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= ACC_ACCUM;
               end
            end
            default: state <= ACC_ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator (Q8.8, mask width 4, 8 guard bits) with a
// reference model feeding a result scoreboard.
module tb_neuron_accumulator;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_w;
   logic [15:0] s_x;
   logic        s_last;
   logic [3:0]  s_mask;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_x;
   logic [3:0]  m_mask;
   logic        m_sat;

   typedef struct packed {
      logic [15:0] x;
      logic [3:0]  mask;
      logic        sat;
   } exp_t;

   exp_t   exp_q[$];
   int     total = 0;
   int     bad   = 0;
   longint acc_m = 0;
   int     beats_m = 0;
   logic [3:0] mask_m = '0;

   neuron_accumulator #(
      .Q_INT     (8),
      .Q_FRAC    (8),
      .MASK_W    (4),
      .ACC_GUARD (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_w     (s_w),
      .s_x     (s_x),
      .s_last  (s_last),
      .s_mask  (s_mask),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_x     (m_x),
      .m_mask  (m_mask),
      .m_sat   (m_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: exact sum, floor to Q8.8, clip, flag over-long vectors.
   task automatic push_expected();
      exp_t   e;
      longint t;
      t      = acc_m >>> 8;
      e.mask = mask_m;
      e.sat  = (beats_m > 256);
      if (t > 32767) begin
         e.x = 16'h7FFF;
         e.sat = 1'b1;
      end else if (t < -32768) begin
         e.x = 16'h8000;
         e.sat = 1'b1;
      end else begin
         e.x = t[15:0];
      end
      exp_q.push_back(e);
      acc_m   = 0;
      beats_m = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(input logic [15:0] w, input logic [15:0] x, input logic last,
                       input logic [3:0] mask);
      int n;
      n       = 0;
      s_valid = 1'b1;
      s_w     = w;
      s_x     = x;
      s_last  = last;
      s_mask  = mask;
      while (!s_ready && n < 40) begin
         tick(1);
         n++;
      end
      chk("beat_accept_timeout", 32'(n < 40), 32'd1);
      tick(1);
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (beats_m == 0) mask_m = mask;
      acc_m += longint'($signed(w)) * longint'($signed(x));
      beats_m++;
      if (last) push_expected();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         tick(1);
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(m_x), 32'hDEAD_BEEF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("m_x", 32'(m_x), 32'(e.x));
            chk("m_mask", 32'(m_mask), 32'(e.mask));
            chk("m_sat", 32'(m_sat), 32'(e.sat));
         end
      end
   end

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_w     = '0;
      s_x     = '0;
      s_last  = 1'b0;
      s_mask  = '0;
      m_ready = 1'b1;
      tick(3);
      rst = 1'b0;

      chk("reset_s_ready", 32'(s_ready), 32'd1);
      chk("reset_m_valid", 32'(m_valid), 32'd0);
      chk("reset_m_x", 32'(m_x), 32'd0);
      chk("reset_m_mask", 32'(m_mask), 32'd0);
      chk("reset_m_sat", 32'(m_sat), 32'd0);

      // 1.5*2.0 + 0.25*-4.0 = 2.0, plus latency check
      beat(16'h0180, 16'h0200, 1'b0, 4'h1);
      beat(16'h0040, 16'hFC00, 1'b1, 4'h1);
      chk("latency_flush_m_valid", 32'(m_valid), 32'd0);
      chk("latency_flush_s_ready", 32'(s_ready), 32'd0);
      tick(1);
      chk("latency_m_valid", 32'(m_valid), 32'd1);
      drain();

      // Saturation both ways
      beat(16'h6400, 16'h6400, 1'b1, 4'h2);
      beat(16'h9C00, 16'h6400, 1'b1, 4'h3);
      // Truncation toward -inf
      beat(16'h0001, 16'h0001, 1'b1, 4'h4);
      beat(16'hFFFF, 16'h0001, 1'b1, 4'h5);
      drain();

      // Backpressure: result held for 5 cycles, then back-to-back vector
      m_ready = 1'b0;
      beat(16'h0100, 16'h0300, 1'b1, 4'h6);
      begin
         int n;
         n = 0;
         while (!m_valid && n < 20) begin
            tick(1);
            n++;
         end
         chk("hold_valid_timeout", 32'(m_valid), 32'd1);
      end
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("hold_m_x", 32'(m_x), 32'h0300);
         chk("hold_m_mask", 32'(m_mask), 32'h6);
         chk("hold_s_ready", 32'(s_ready), 32'd0);
      end
      m_ready = 1'b1;
      tick(1);
      chk("release_s_ready", 32'(s_ready), 32'd1);
      beat(16'h0080, 16'h0200, 1'b1, 4'h9);
      drain();

      // Mask latched on first beat, s_valid gaps inside the vector
      beat(16'h0100, 16'h0100, 1'b0, 4'h2);
      tick(3);
      beat(16'h0200, 16'h0080, 1'b0, 4'h3);
      tick(3);
      beat(16'hFF00, 16'h0040, 1'b1, 4'h3);
      drain();

      // Reset mid-vector discards the partial sum
      beat(16'h1000, 16'h0100, 1'b0, 4'hA);
      beat(16'h1000, 16'h0100, 1'b0, 4'hA);
      beat(16'h1000, 16'h0100, 1'b0, 4'hA);
      rst = 1'b1;
      tick(1);
      rst     = 1'b0;
      acc_m   = 0;
      beats_m = 0;
      chk("midreset_m_valid", 32'(m_valid), 32'd0);
      chk("midreset_s_ready", 32'(s_ready), 32'd1);
      beat(16'h0100, 16'h0100, 1'b1, 4'hC);
      drain();

      // Beat-count limit: 256 beats is fine, 257 flags m_sat
      for (int i = 0; i < 256; i++) beat(16'h0000, 16'h0000, 1'(i == 255), 4'h7);
      drain();
      for (int i = 0; i < 257; i++) beat(16'h0001, 16'h0100, 1'(i == 256), 4'h8);
      drain();

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
